// File: rtl/rf_pkg.sv
// Register-file package: register count, PC address and common data types.
// It is shared by the register file and its write-back arbiter.
package rf_pkg;

   localparam int unsigned NUM_REGS    = 16;
   localparam int unsigned PC_REG_ADDR = 15;

   typedef logic [3:0]  reg_addr_t;
   typedef logic [31:0] word_t;

endpackage

// File: rtl/rf_wb_arbiter_if.sv
// Write-back bus interface.
// It carries the requester handshake (valid/ready/addr/data, hold), the
// register-file write port and the PC-redirect output.
// master: the requester and consumer side.
// slave:  the arbiter.
interface rf_wb_arbiter_if #(
   parameter int unsigned NUM_REQ = 3,
   parameter int unsigned DATA_W  = 32,
   parameter int unsigned ADDR_W  = 4
);

   logic [NUM_REQ-1:0]        req_valid;
   logic [NUM_REQ-1:0]        req_ready;
   logic [NUM_REQ*ADDR_W-1:0] req_addr;
   logic [NUM_REQ*DATA_W-1:0] req_data;
   logic                      wb_hold;

   logic                      rf_we;
   logic [ADDR_W-1:0]         rf_a3;
   logic [DATA_W-1:0]         rf_wd3;
   logic                      pc_wr_valid;
   logic [DATA_W-1:0]         pc_wr_data;

   modport master (
      output req_valid, req_addr, req_data, wb_hold,
      input  req_ready, rf_we, rf_a3, rf_wd3, pc_wr_valid, pc_wr_data
   );

   modport slave (
      input  req_valid, req_addr, req_data, wb_hold,
      output req_ready, rf_we, rf_a3, rf_wd3, pc_wr_valid, pc_wr_data
   );

endinterface

// File: rtl/rf_wb_arbiter_rr_arbiter.sv
// N-way request arbiter: a one-hot grant, or no grant at all.
// Default build: round-robin arbitration. The search starts at a pointer, and
// the pointer moves to one past the last winner.
// With RF_WB_FIXED_PRIO_EN defined: fixed priority, where the lowest index
// wins. This variant has no pointer.
module rr_arbiter #(
   parameter int unsigned N = 3
) (
   input  logic         clk,
   input  logic         reset,
   input  logic [N-1:0] req,
   input  logic         hold,
   output logic [N-1:0] gnt
);

`ifdef RF_WB_FIXED_PRIO_EN

   // lowest-index valid requester wins unless held
   always_comb begin
      gnt = '0;
      if (!hold) begin
         for (int unsigned i = 0; i < N; i++) begin
            if (req[i] && (gnt == '0)) gnt[i] = 1'b1;
         end
      end
   end

`else

   localparam int unsigned PTR_W = (N > 1) ? $clog2(N) : 1;

   logic [PTR_W-1:0] ptr;
   logic [PTR_W-1:0] win;
   logic             found;

   // Two passes replace the modulo rotation. The first pass looks at
   // indices >= ptr. The second pass wraps around to the lowest index.
   always_comb begin
      gnt   = '0;
      win   = '0;
      found = 1'b0;
      if (!hold) begin
         for (int unsigned i = 0; i < N; i++) begin
            if (!found && req[i] && (i >= 32'(ptr))) begin
               found  = 1'b1;
               gnt[i] = 1'b1;
               win    = PTR_W'(i);
            end
         end
         for (int unsigned i = 0; i < N; i++) begin
            if (!found && req[i]) begin
               found  = 1'b1;
               gnt[i] = 1'b1;
               win    = PTR_W'(i);
            end
         end
      end
   end

   // advance the pointer past the winner; keep it when nothing is granted
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         ptr <= '0;
      end else if (found) begin
         ptr <= (win == PTR_W'(N - 1)) ? '0 : win + 1'b1;
      end
   end

`endif

endmodule

// File: rtl/rf_wb_arbiter.sv
// Write-back arbiter and pending-write scoreboard for the 16-entry register file.
// It shares the single write port between NUM_REQ sources and diverts writes
// to the PC register onto a redirect pulse.
// It also flags RAW hazards on the decode read addresses.
// Optional macro RF_WB_FIXED_PRIO_EN selects fixed-priority arbitration.
module rf_wb_arbiter
   import rf_pkg::*;
#(
   parameter int unsigned NUM_REQ = 3,
   parameter int unsigned DATA_W  = 32,
   parameter int unsigned ADDR_W  = 4,
   parameter int unsigned PC_ADDR = PC_REG_ADDR
) (
   input  logic                clk,
   input  logic                reset,
   rf_wb_arbiter_if.slave      bus,
   input  logic                issue_valid,
   input  logic [ADDR_W-1:0]   issue_rd,
   input  logic [ADDR_W-1:0]   chk_a1,
   input  logic [ADDR_W-1:0]   chk_a2,
   output logic                hazard,
   output logic [NUM_REGS-1:0] pending
);

   logic                xfer;
   logic                is_pc;
   logic [ADDR_W-1:0]   sel_addr;
   logic [DATA_W-1:0]   sel_data;
   logic [NUM_REGS-1:0] set_mask;
   logic [NUM_REGS-1:0] clr_mask;
   logic [NUM_REGS-1:0] pend_next;

   rr_arbiter #(.N(NUM_REQ)) u_arb (
      .clk   (clk),
      .reset (reset),
      .req   (bus.req_valid),
      .hold  (bus.wb_hold),
      .gnt   (bus.req_ready)
   );

   // mux the granted requester's address and data onto the write path
   always_comb begin
      sel_addr = '0;
      sel_data = '0;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         if (bus.req_ready[i]) begin
            sel_addr = bus.req_addr[i*ADDR_W +: ADDR_W];
            sel_data = bus.req_data[i*DATA_W +: DATA_W];
         end
      end
      xfer  = |(bus.req_valid & bus.req_ready);
      is_pc = (sel_addr == ADDR_W'(PC_ADDR));
   end

   // register the write port or the PC redirect one cycle after the transfer
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         bus.rf_we       <= 1'b0;
         bus.rf_a3       <= '0;
         bus.rf_wd3      <= '0;
         bus.pc_wr_valid <= 1'b0;
         bus.pc_wr_data  <= '0;
      end else begin
         bus.rf_we       <= xfer && !is_pc;
         bus.pc_wr_valid <= xfer && is_pc;
         if (xfer && !is_pc) begin
            bus.rf_a3  <= sel_addr;
            bus.rf_wd3 <= sel_data;
         end
         if (xfer && is_pc) begin
            bus.pc_wr_data <= sel_data;
         end
      end
   end

   // The set is applied after the clear, so a newly issued producer outranks
   // a write that completes in the same cycle.
   always_comb begin
      set_mask = '0;
      clr_mask = '0;
      if (issue_valid) set_mask[issue_rd] = 1'b1;
      if (xfer)        clr_mask[sel_addr] = 1'b1;
      pend_next = (pending & ~clr_mask) | set_mask;
   end

   // scoreboard register
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) pending <= '0;
      else        pending <= pend_next;
   end

   assign hazard = pending[chk_a1] | pending[chk_a2];

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Directed testbench for rf_wb_arbiter (NUM_REQ=3).
module tb_rf_wb_arbiter;
   import rf_pkg::*;

   localparam word_t     D0 = 32'h1111_0000;
   localparam word_t     D1 = 32'h0000_0100;
   localparam word_t     D2 = 32'h3333_0000;
   localparam logic [11:0] A = 12'h321;    // req2=3, req1=2, req0=1

   logic        clk = 1'b0;
   logic        reset;
   logic        issue_valid;
   reg_addr_t   issue_rd, chk_a1, chk_a2;
   logic        hazard;
   logic [15:0] pending;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [2:0]  valid;
      logic        hold;
      logic [11:0] addr;
      logic        iv;
      logic [3:0]  ird;
      logic [3:0]  c1;
      logic [3:0]  c2;
      logic [2:0]  e_ready;
      logic        e_haz;
      logic        e_we;
      logic [3:0]  e_a3;
      logic [31:0] e_wd3;
      logic        e_pcv;
      logic [31:0] e_pcd;
      logic [15:0] e_pend;
   } vec_t;

   vec_t vecs[24];

   rf_wb_arbiter_if #(.NUM_REQ(3), .DATA_W(32), .ADDR_W(4)) bus ();

   rf_wb_arbiter #(.NUM_REQ(3), .DATA_W(32), .ADDR_W(4), .PC_ADDR(15)) dut (
      .clk         (clk),
      .reset       (reset),
      .bus         (bus),
      .issue_valid (issue_valid),
      .issue_rd    (issue_rd),
      .chk_a1      (chk_a1),
      .chk_a2      (chk_a2),
      .hazard      (hazard),
      .pending     (pending)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %h exp %h", name, act, exp);
      end
   endtask

   initial begin
      // row layout: valid hold addr iv ird c1 c2 | ready haz we a3 wd3 pcv pcd pend
      vecs[0]  = '{3'b111,1'b0,A,1'b0,4'd0,4'd0,4'd0, 3'b001,1'b0,1'b1,4'd1,D0,1'b0,32'h0,16'h0};
      vecs[1]  = '{3'b111,1'b0,A,1'b0,4'd0,4'd0,4'd0, 3'b010,1'b0,1'b1,4'd2,D1,1'b0,32'h0,16'h0};
      vecs[2]  = '{3'b111,1'b0,A,1'b0,4'd0,4'd0,4'd0, 3'b100,1'b0,1'b1,4'd3,D2,1'b0,32'h0,16'h0};
      vecs[3]  = '{3'b111,1'b0,A,1'b0,4'd0,4'd0,4'd0, 3'b001,1'b0,1'b1,4'd1,D0,1'b0,32'h0,16'h0};
      vecs[4]  = '{3'b111,1'b0,A,1'b0,4'd0,4'd0,4'd0, 3'b010,1'b0,1'b1,4'd2,D1,1'b0,32'h0,16'h0};
      vecs[5]  = '{3'b111,1'b0,A,1'b0,4'd0,4'd0,4'd0, 3'b100,1'b0,1'b1,4'd3,D2,1'b0,32'h0,16'h0};
      vecs[6]  = '{3'b111,1'b1,A,1'b0,4'd0,4'd0,4'd0, 3'b000,1'b0,1'b0,4'd3,D2,1'b0,32'h0,16'h0};
      vecs[7]  = '{3'b111,1'b1,A,1'b0,4'd0,4'd0,4'd0, 3'b000,1'b0,1'b0,4'd3,D2,1'b0,32'h0,16'h0};
      vecs[8]  = '{3'b111,1'b1,A,1'b0,4'd0,4'd0,4'd0, 3'b000,1'b0,1'b0,4'd3,D2,1'b0,32'h0,16'h0};
      vecs[9]  = '{3'b111,1'b0,A,1'b0,4'd0,4'd0,4'd0, 3'b001,1'b0,1'b1,4'd1,D0,1'b0,32'h0,16'h0};
      vecs[10] = '{3'b000,1'b0,A,1'b0,4'd0,4'd0,4'd0, 3'b000,1'b0,1'b0,4'd1,D0,1'b0,32'h0,16'h0};
      vecs[11] = '{3'b100,1'b0,A,1'b0,4'd0,4'd0,4'd0, 3'b100,1'b0,1'b1,4'd3,D2,1'b0,32'h0,16'h0};
      vecs[12] = '{3'b110,1'b0,A,1'b0,4'd0,4'd0,4'd0, 3'b010,1'b0,1'b1,4'd2,D1,1'b0,32'h0,16'h0};
      vecs[13] = '{3'b001,1'b0,A,1'b0,4'd0,4'd0,4'd0, 3'b001,1'b0,1'b1,4'd1,D0,1'b0,32'h0,16'h0};
      vecs[14] = '{3'b010,1'b0,12'h3F1,1'b0,4'd0,4'd0,4'd0, 3'b010,1'b0,1'b0,4'd1,D0,1'b1,32'h100,16'h0};
      vecs[15] = '{3'b000,1'b0,A,1'b0,4'd0,4'd0,4'd0, 3'b000,1'b0,1'b0,4'd1,D0,1'b0,32'h100,16'h0};
      vecs[16] = '{3'b000,1'b0,A,1'b1,4'd5,4'd5,4'd0, 3'b000,1'b0,1'b0,4'd1,D0,1'b0,32'h100,16'h0020};
      vecs[17] = '{3'b000,1'b0,A,1'b0,4'd0,4'd5,4'd0, 3'b000,1'b1,1'b0,4'd1,D0,1'b0,32'h100,16'h0020};
      vecs[18] = '{3'b000,1'b0,A,1'b0,4'd0,4'd0,4'd5, 3'b000,1'b1,1'b0,4'd1,D0,1'b0,32'h100,16'h0020};
      vecs[19] = '{3'b001,1'b0,12'h325,1'b0,4'd0,4'd5,4'd0, 3'b001,1'b1,1'b1,4'd5,D0,1'b0,32'h100,16'h0};
      vecs[20] = '{3'b000,1'b0,A,1'b0,4'd0,4'd5,4'd0, 3'b000,1'b0,1'b0,4'd5,D0,1'b0,32'h100,16'h0};
      vecs[21] = '{3'b001,1'b0,12'h325,1'b1,4'd5,4'd5,4'd0, 3'b001,1'b0,1'b1,4'd5,D0,1'b0,32'h100,16'h0020};
      vecs[22] = '{3'b000,1'b0,A,1'b0,4'd0,4'd5,4'd0, 3'b000,1'b1,1'b0,4'd5,D0,1'b0,32'h100,16'h0020};
      vecs[23] = '{3'b010,1'b0,12'h371,1'b0,4'd0,4'd5,4'd0, 3'b010,1'b1,1'b1,4'd7,D1,1'b0,32'h100,16'h0020};

      reset         = 1'b0;
      bus.req_valid = '0;
      bus.req_addr  = A;
      bus.req_data  = {D2, D1, D0};
      bus.wb_hold   = 1'b0;
      issue_valid   = 1'b0;
      issue_rd      = '0;
      chk_a1        = '0;
      chk_a2        = '0;
      repeat (2) @(negedge clk);
      reset = 1'b1;

      // reset during active writes: pending and outputs clear at once
      @(negedge clk);
      bus.req_valid = 3'b111;
      issue_valid   = 1'b1;
      issue_rd      = 4'd9;
      @(posedge clk);
      @(negedge clk);
      issue_valid = 1'b0;
      @(posedge clk);
      #1;
      chk("pre_rst_we", 32'(bus.rf_we), 32'h1);
      chk("pre_rst_pend", 32'(pending), 32'h0200);
      #1 reset = 1'b0;
      #1;
      chk("rst_we", 32'(bus.rf_we), 32'h0);
      chk("rst_a3", 32'(bus.rf_a3), 32'h0);
      chk("rst_wd3", bus.rf_wd3, 32'h0);
      chk("rst_pcv", 32'(bus.pc_wr_valid), 32'h0);
      chk("rst_pcd", bus.pc_wr_data, 32'h0);
      chk("rst_pend", 32'(pending), 32'h0);
      reset = 1'b1;
      #1;
      chk("post_rst_ready", 32'(bus.req_ready), 32'h1);

`ifdef RF_WB_FIXED_PRIO_EN
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         bus.req_valid = 3'b111;
         #1;
         chk($sformatf("fp%0d_ready", k), 32'(bus.req_ready), 32'h1);
         @(posedge clk);
         #1;
         chk($sformatf("fp%0d_a3", k), 32'(bus.rf_a3), 32'h1);
      end
`else
      for (int k = 0; k < 24; k++) begin
         @(negedge clk);
         bus.req_valid = vecs[k].valid;
         bus.wb_hold   = vecs[k].hold;
         bus.req_addr  = vecs[k].addr;
         issue_valid   = vecs[k].iv;
         issue_rd      = vecs[k].ird;
         chk_a1        = vecs[k].c1;
         chk_a2        = vecs[k].c2;
         #1;
         chk($sformatf("v%0d_ready", k), 32'(bus.req_ready), 32'(vecs[k].e_ready));
         chk($sformatf("v%0d_hazard", k), 32'(hazard), 32'(vecs[k].e_haz));
         @(posedge clk);
         #1;
         chk($sformatf("v%0d_we", k), 32'(bus.rf_we), 32'(vecs[k].e_we));
         chk($sformatf("v%0d_a3", k), 32'(bus.rf_a3), 32'(vecs[k].e_a3));
         chk($sformatf("v%0d_wd3", k), bus.rf_wd3, vecs[k].e_wd3);
         chk($sformatf("v%0d_pcv", k), 32'(bus.pc_wr_valid), 32'(vecs[k].e_pcv));
         chk($sformatf("v%0d_pcd", k), bus.pc_wr_data, vecs[k].e_pcd);
         chk($sformatf("v%0d_pend", k), 32'(pending), 32'(vecs[k].e_pend));
      end
`endif

      @(negedge clk);
      bus.req_valid = '0;
      issue_valid   = 1'b0;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
